key_expand_serial: RTL and testbench

- Byte-serial AES key-expansion engine. Successor to the single-byte key-schedule combine stage.
- Parametrised for AES-128, AES-192 and AES-256 (NK = 4/6/8), with an internal Rcon generator and a configurable-latency external S-box port.
- Accepts the cipher key one byte per handshake, then streams every round-key byte in order over a valid/ready interface to the byte-serial datapath.
- Sits between the key-load interface and the shared SSbox instance.

---
 rtl/key_expand_serial_pkg.sv | 32 +++
 rtl/ks_rcon_gen.sv | 38 +++
 rtl/key_expand_serial.sv | 195 +++++++++++++++++++
 tb/tb_key_expand_serial.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_expand_serial_pkg.sv
// Shared definitions for the byte-serial AES key-expansion engine.
//   - ks_nr / ks_total_bytes : round count and round-key byte count for a given NK
//   - RCON_POLY / RCON_INIT  : GF(2^8) reduction constant and first Rcon value
//   - ks_state_e             : engine state encoding
//   - xtime                  : multiply-by-x in GF(2^8)
package key_expand_serial_pkg;

    localparam logic [7:0] RCON_POLY = 8'h1b;
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CALC  = 3'd2,
        ST_SWAIT = 3'd3,
        ST_OUT   = 3'd4
    } ks_state_e;

    function automatic int ks_nr(input int nk);
        return nk + 6;
    endfunction

    // 16 bytes per round key, NR+1 round keys.
    function automatic int ks_total_bytes(input int nk);
        return 16 * (ks_nr(nk) + 1);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/ks_rcon_gen.sv
// Rcon generator: 8-bit register holding the current round constant.
//   clk, rst : clock, asynchronous active-high reset (value returns to 01)
//   init     : reload 01 (start of a new key)
//   advance  : step to xtime(rcon)
//   rcon     : current round constant
module ks_rcon_gen
    import key_expand_serial_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       init,
    input  logic       advance,
    output logic [7:0] rcon
);

    logic [7:0] rcon_q;
    logic [7:0] rcon_d;

    always_comb begin
        rcon_d = rcon_q;
        if (init) begin
            rcon_d = RCON_INIT;
        end else if (advance) begin
            rcon_d = xtime(rcon_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcon_q <= RCON_INIT;
        end else begin
            rcon_q <= rcon_d;
        end
    end

    assign rcon = rcon_q;

endmodule

// File: rtl/key_expand_serial.sv
// Byte-serial AES key expansion (AES-128/192/256 via NK = 4/6/8).
// Loads the cipher key one byte per key_valid/key_ready handshake, then streams
// every round-key byte over rk_valid/rk_ready, using an external shared S-box
// with SBOX_LAT cycles of latency.
//   start, key_in, key_valid, key_ready : key-load interface
//   sbox_in (registered), sbox_out      : shared S-box port
//   rk_out (registered), rk_valid, rk_ready, rk_last, round_idx : round-key stream
//   busy                                : engine not idle
module key_expand_serial
    import key_expand_serial_pkg::*;
#(
    parameter int NK       = 4,
    parameter int SBOX_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] key_in,
    input  logic       key_valid,
    output logic       key_ready,
    output logic [7:0] sbox_in,
    input  logic [7:0] sbox_out,
    output logic [7:0] rk_out,
    output logic       rk_valid,
    input  logic       rk_ready,
    output logic       rk_last,
    output logic [3:0] round_idx,
    output logic       busy
);

    localparam int         WIN       = 4 * NK;
    localparam int         IW        = $clog2(WIN);
    localparam logic [7:0] LAST_CNT  = 8'(ks_total_bytes(NK) - 1);
    localparam logic [7:0] KEY_BYTES = 8'(WIN);
    localparam logic [7:0] LOAD_LAST = 8'(WIN - 1);
    localparam logic [3:0] WMOD_LAST = 4'(NK - 1);
    localparam logic [1:0] LAT_LAST  = 2'(SBOX_LAT - 1);

    ks_state_e  state_q, state_d;
    logic [7:0] window_q [WIN];
    logic [7:0] window_d [WIN];
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] wmod_q, wmod_d;     // word index mod NK
    logic [1:0] lat_q, lat_d;
    logic [7:0] rk_out_q, rk_out_d;
    logic [7:0] sbox_in_q, sbox_in_d;

    logic       shift_en;
    logic [7:0] shift_byte;
    logic       rcon_init, rcon_adv;
    logic [7:0] rcon;

    ks_rcon_gen u_rcon (
        .clk     (clk),
        .rst     (rst),
        .init    (rcon_init),
        .advance (rcon_adv),
        .rcon    (rcon)
    );

    // Window: position 0 is the oldest byte; new bytes enter at WIN-1.
    genvar gi;
    for (gi = 0; gi < WIN; gi++) begin : g_win
        if (gi == WIN - 1) begin : g_tail
            assign window_d[gi] = shift_en ? shift_byte : window_q[gi];
        end else begin : g_body
            assign window_d[gi] = shift_en ? window_q[gi + 1] : window_q[gi];
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                window_q[gi] <= 8'h00;
            end else begin
                window_q[gi] <= window_d[gi];
            end
        end
    end

    // Byte/word decode of the byte currently being produced.
    logic [1:0]    j;
    logic          key_word, rot_word, sub_word, rcon_byte;
    logic [1:0]    k_sel;
    logic [IW-1:0] sub_idx;

    assign j         = cnt_q[1:0];
    assign key_word  = (cnt_q < KEY_BYTES);
    assign rot_word  = (wmod_q == 4'd0);
    assign sub_word  = !key_word && (rot_word || (NK == 8 && wmod_q == 4'd4));
    assign rcon_byte = !key_word && rot_word && (j == 2'd0);
    // RotWord picks the next byte of w[i-1]; the 2-bit add wraps mod 4.
    assign k_sel     = rot_word ? j + 2'd1 : j;
    // w[i-1] byte k sits at window position WIN-4+k-j.
    assign sub_idx   = IW'(WIN - 4) + IW'(k_sel) - IW'(j);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wmod_d     = wmod_q;
        lat_d      = lat_q;
        rk_out_d   = rk_out_q;
        sbox_in_d  = sbox_in_q;
        shift_en   = 1'b0;
        shift_byte = key_in;
        rcon_init  = 1'b0;
        rcon_adv   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    cnt_d     = 8'd0;
                    rcon_init = 1'b1;
                end
            end
            ST_LOAD: begin
                if (key_valid) begin
                    shift_en = 1'b1;
                    if (cnt_q == LOAD_LAST) begin
                        cnt_d   = 8'd0;
                        wmod_d  = 4'd0;
                        state_d = ST_CALC;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ST_CALC: begin
                if (key_word) begin
                    rk_out_d = window_q[0];
                    state_d  = ST_OUT;
                end else if (sub_word) begin
                    sbox_in_d = window_q[sub_idx];
                    lat_d     = 2'd0;
                    state_d   = ST_SWAIT;
                end else begin
                    rk_out_d = window_q[0] ^ window_q[WIN-4];
                    state_d  = ST_OUT;
                end
            end
            ST_SWAIT: begin
                if (lat_q == LAT_LAST) begin
                    rk_out_d = window_q[0] ^ sbox_out ^ (rcon_byte ? rcon : 8'h00);
                    state_d  = ST_OUT;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            ST_OUT: begin
                if (rk_ready) begin
                    // Key words re-enter the window, so it always holds the last WIN bytes.
                    shift_en   = 1'b1;
                    shift_byte = rk_out_q;
                    rcon_adv   = rcon_byte;
                    if (j == 2'd3) begin
                        wmod_d = (wmod_q == WMOD_LAST) ? 4'd0 : wmod_q + 4'd1;
                    end
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = 8'd0;
                        wmod_d  = 4'd0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        state_d = ST_CALC;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            wmod_q    <= 4'd0;
            lat_q     <= 2'd0;
            rk_out_q  <= 8'h00;
            sbox_in_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wmod_q    <= wmod_d;
            lat_q     <= lat_d;
            rk_out_q  <= rk_out_d;
            sbox_in_q <= sbox_in_d;
        end
    end

    assign key_ready = (state_q == ST_LOAD);
    assign rk_valid  = (state_q == ST_OUT);
    assign rk_last   = (state_q == ST_OUT) && (cnt_q == LAST_CNT);
    assign round_idx = (state_q == ST_OUT) ? cnt_q[7:4] : 4'd0;
    assign busy      = (state_q != ST_IDLE);
    assign rk_out    = rk_out_q;
    assign sbox_in   = sbox_in_q;

endmodule

// File: tb/tb_key_expand_serial.sv
// Bench for key_expand_serial: four instances (AES-128, AES-192, AES-256 with a
// combinational S-box, AES-128 with a 3-cycle S-box), each fed from a reference
// key-expansion model through an expected-byte queue.
module tb_key_expand_serial;

    localparam int ND = 4;
    localparam int NKS  [ND] = '{4, 6, 8, 4};
    localparam int LATS [ND] = '{1, 1, 1, 3};

    logic       clk = 1'b0;
    logic       rst;
    logic       start     [ND];
    logic [7:0] key_in    [ND];
    logic       key_valid [ND];
    logic       key_ready [ND];
    logic [7:0] sbox_in   [ND];
    logic [7:0] sbox_out  [ND];
    logic [7:0] rk_out    [ND];
    logic       rk_valid  [ND];
    logic       rk_ready  [ND];
    logic       rk_last   [ND];
    logic [3:0] round_idx [ND];
    logic       busy      [ND];

    int err_cnt = 0;
    int chk_cnt = 0;
    int cyc = 0;

    logic [7:0] model_ek [240];
    logic [7:0] got      [240];
    int         tacc     [240];
    logic [7:0] exp_q    [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int n = 0; n < 8; n++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // AES S-box from first principles: inverse (v^254) followed by the affine map.
    function automatic logic [7:0] sbox_f(input logic [7:0] v);
        logic [7:0] inv = 8'h01;
        for (int n = 0; n < 254; n++) inv = gmul(inv, v);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    genvar gi;
    for (gi = 0; gi < ND; gi++) begin : g_dut
        logic [7:0] s0;
        logic [7:0] pipe [1:3];
        always_comb s0 = sbox_f(sbox_in[gi]);
        always @(posedge clk) begin
            pipe[1] <= s0;
            pipe[2] <= pipe[1];
            pipe[3] <= pipe[2];
        end
        if (LATS[gi] == 1) begin : g_comb
            assign sbox_out[gi] = s0;
        end else begin : g_pipe
            assign sbox_out[gi] = pipe[LATS[gi]-1];
        end

        key_expand_serial #(.NK(NKS[gi]), .SBOX_LAT(LATS[gi])) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start[gi]),
            .key_in    (key_in[gi]),
            .key_valid (key_valid[gi]),
            .key_ready (key_ready[gi]),
            .sbox_in   (sbox_in[gi]),
            .sbox_out  (sbox_out[gi]),
            .rk_out    (rk_out[gi]),
            .rk_valid  (rk_valid[gi]),
            .rk_ready  (rk_ready[gi]),
            .rk_last   (rk_last[gi]),
            .round_idx (round_idx[gi]),
            .busy      (busy[gi])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] req);
        chk_cnt++;
        if (act !== req) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, act, req);
        end
    endtask

    // Textbook word-oriented key expansion; key is left-aligned in 256 bits.
    task automatic expand_model(input logic [255:0] key, input int nk);
        logic [7:0] rc = 8'h01;
        logic [7:0] t [4];
        logic [7:0] t0;
        for (int b = 0; b < 4 * nk; b++) model_ek[b] = key[255 - 8*b -: 8];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            for (int k = 0; k < 4; k++) t[k] = model_ek[4*(i-1) + k];
            if (i % nk == 0) begin
                t0 = t[0]; t[0] = t[1]; t[1] = t[2]; t[2] = t[3]; t[3] = t0;
                for (int k = 0; k < 4; k++) t[k] = sbox_f(t[k]);
                t[0] = t[0] ^ rc;
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk == 8 && i % nk == 4) begin
                for (int k = 0; k < 4; k++) t[k] = sbox_f(t[k]);
            end
            for (int k = 0; k < 4; k++) model_ek[4*i + k] = model_ek[4*(i-nk) + k] ^ t[k];
        end
    endtask

    task automatic check_word(input string tag, input int base, input logic [31:0] w);
        check_eq(tag, {got[base], got[base+1], got[base+2], got[base+3]}, w);
    endtask

    task automatic check_idle_outputs(input string tag, input int d);
        check_eq({tag, "_rk_valid"},  32'(rk_valid[d]),  32'd0);
        check_eq({tag, "_busy"},      32'(busy[d]),      32'd0);
        check_eq({tag, "_key_ready"}, 32'(key_ready[d]), 32'd0);
        check_eq({tag, "_rk_out"},    32'(rk_out[d]),    32'd0);
        check_eq({tag, "_sbox_in"},   32'(sbox_in[d]),   32'd0);
        check_eq({tag, "_rk_last"},   32'(rk_last[d]),   32'd0);
        check_eq({tag, "_round_idx"}, 32'(round_idx[d]), 32'd0);
    endtask

    // Load a key into instance d and consume its stream. rnd: random key_valid /
    // rk_ready plus a 10-cycle stall at byte 17. abort_at >= 0: pulse start at
    // byte 20 and assert rst once abort_at bytes have been consumed.
    task automatic run_stream(input int d, input logic [255:0] key, input bit rnd,
                              input int abort_at, input bit timing);
        int nk = NKS[d];
        int total = 16 * (nk + 7);
        int b = 0, guard = 0, idx = 0, stall = 0;
        bit done = 0, poked = 0, hold_v = 0, rdy;
        logic [7:0] hold_d, e;
        logic hold_l;
        logic [3:0] hold_r, last_round = 4'd0;

        expand_model(key, nk);
        exp_q.delete();
        for (int n = 0; n < total; n++) exp_q.push_back(model_ek[n]);

        @(negedge clk); start[d] = 1'b1;
        @(negedge clk); start[d] = 1'b0;
        check_eq("key_ready_load", 32'(key_ready[d]), 32'd1);

        while (b < 4 * nk && guard < 400) begin
            key_valid[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            key_in[d] = key[255 - 8*b -: 8];
            if (key_ready[d] && key_valid[d]) b++;
            @(negedge clk); guard++;
        end
        key_valid[d] = 1'b0;
        check_eq("load_bytes", 32'(b), 32'(4 * nk));
        check_eq("key_ready_drop", 32'(key_ready[d]), 32'd0);

        guard = 0;
        while (!done && guard < 6000) begin
            if (abort_at >= 0 && idx >= abort_at) begin
                #2 rst = 1'b1;
                #1 check_idle_outputs("async_rst", d);
                break;
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rnd && idx == 17 && stall < 10 && rk_valid[d]) begin
                rdy = 1'b0;
                stall++;
            end
            start[d] = (abort_at >= 0 && idx == 20 && !poked);
            if (start[d]) poked = 1;
            rk_ready[d] = rdy;
            if (hold_v) begin
                check_eq("hold_valid", 32'(rk_valid[d]),  32'd1);
                check_eq("hold_data",  32'(rk_out[d]),    32'(hold_d));
                check_eq("hold_last",  32'(rk_last[d]),   32'(hold_l));
                check_eq("hold_round", 32'(round_idx[d]), 32'(hold_r));
            end
            hold_v = 0;
            if (rk_valid[d]) begin
                if (rdy) begin
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check_eq("rk_byte", 32'(rk_out[d]), 32'(e));
                    end else begin
                        check_eq("extra_byte", 32'(idx), 32'(total));
                    end
                    check_eq("rk_last", 32'(rk_last[d]), 32'(idx == total - 1));
                    check_eq("round_idx", 32'(round_idx[d]), 32'(idx >> 4));
                    $display("dut%0d byte %0d rk=%02h round=%0d last=%0d",
                             d, idx, rk_out[d], round_idx[d], rk_last[d]);
                    if (idx < 240) begin
                        got[idx] = rk_out[d];
                        tacc[idx] = cyc;
                    end
                    last_round = round_idx[d];
                    if (rk_last[d]) done = 1;
                    idx++;
                end else begin
                    hold_v = 1;
                    hold_d = rk_out[d];
                    hold_l = rk_last[d];
                    hold_r = round_idx[d];
                end
            end
            @(negedge clk); guard++;
        end
        start[d] = 1'b0;
        rk_ready[d] = 1'b0;
        if (abort_at < 0) begin
            check_eq("stream_done", 32'(done), 32'd1);
            check_eq("byte_count", 32'(idx), 32'(total));
            check_eq("final_round", 32'(last_round), 32'(nk + 6));
            check_eq("post_busy", 32'(busy[d]), 32'd0);
            check_eq("post_valid", 32'(rk_valid[d]), 32'd0);
            if (timing) begin
                check_eq("key_spacing",  32'(tacc[1] - tacc[0]),   32'd2);
                check_eq("sub_spacing",  32'(tacc[16] - tacc[15]), 32'(LATS[d] + 2));
                check_eq("sub_spacing2", 32'(tacc[17] - tacc[16]), 32'(LATS[d] + 2));
                check_eq("plain_spacing", 32'(tacc[21] - tacc[20]), 32'd2);
            end
        end
    endtask

    task automatic check_aes128(input string tag);
        check_word({tag, "_w0"},  0,   32'h2b7e1516);
        check_word({tag, "_w4"},  16,  32'ha0fafe17);
        check_word({tag, "_w43"}, 172, 32'hb6630ca6);
    endtask

    logic [255:0] k128, k192, k256;

    initial begin
        k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
        k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        rst = 1'b1;
        for (int d = 0; d < ND; d++) begin
            start[d] = 1'b0; key_in[d] = 8'h00; key_valid[d] = 1'b0; rk_ready[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) check_idle_outputs("reset", d);
        rst = 1'b0;
        @(negedge clk);

        run_stream(0, k128, 1'b0, -1, 1'b1);
        check_aes128("aes128");

        run_stream(1, k192, 1'b0, -1, 1'b0);
        check_word("aes192_w6", 24, 32'hfe0c91f7);

        run_stream(2, k256, 1'b0, -1, 1'b0);
        check_word("aes256_w8",  32, 32'h9ba35411);
        check_word("aes256_w12", 48, 32'ha8b09c1a);

        run_stream(0, k128, 1'b1, -1, 1'b0);
        check_aes128("bp");

        run_stream(3, k128, 1'b0, -1, 1'b1);
        check_aes128("lat3");

        run_stream(0, k128, 1'b0, 50, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("after_rst_busy", 32'(busy[0]), 32'd0);
        run_stream(0, k128, 1'b0, -1, 1'b1);
        check_aes128("reload");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
